// File: rtl/d2d_pkg.sv
// Shared die-to-die link definitions used by both the transmit and receive ends.
package d2d_pkg;

  localparam int unsigned D2D_CREDITS_DFLT = 8;
  localparam int unsigned D2D_WIDTH_DFLT   = 64;

  // Works for non-power-of-2 depths, where the pointer cannot simply overflow.
  function automatic int unsigned ptr_inc(int unsigned ptr, int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/die2die_link_rx_if.sv
// Flit path of the receive end: link side in, consumer side out.
// link_par exists only when D2D_RX_PARITY_EN is defined.
interface die2die_link_rx_if
  import d2d_pkg::*;
#(
  parameter int unsigned WIDTH = D2D_WIDTH_DFLT
);
  logic             link_valid;
  logic [WIDTH-1:0] link_data;
`ifdef D2D_RX_PARITY_EN
  logic             link_par;
`endif
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  modport master (
`ifdef D2D_RX_PARITY_EN
    output link_par,
`endif
    output link_valid, link_data, out_ready,
    input  out_valid, out_data
  );

  modport slave (
`ifdef D2D_RX_PARITY_EN
    input  link_par,
`endif
    input  link_valid, link_data, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/die2die_rx_fifo.sv
// CREDITS-deep first-word-fall-through buffer with wrap-around pointers.
module die2die_rx_fifo
  import d2d_pkg::*;
#(
  parameter int unsigned CREDITS = D2D_CREDITS_DFLT,
  parameter int unsigned WIDTH   = D2D_WIDTH_DFLT
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(CREDITS):0]   count
);
  localparam int unsigned PtrW = $clog2(CREDITS);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem [CREDITS];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = PtrW'(ptr_inc(32'(wr_ptr_q), CREDITS));
    if (pop)  rd_ptr_d = PtrW'(ptr_inc(32'(rd_ptr_q), CREDITS));
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is qualified by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/die2die_link_rx.sv
// Receive end of the credit-based die-to-die link: buffering, drop logic and credit return.
// Optional parity checking is enabled by defining D2D_RX_PARITY_EN.
module die2die_link_rx
  import d2d_pkg::*;
#(
  parameter int unsigned CREDITS = D2D_CREDITS_DFLT,
  parameter int unsigned WIDTH   = D2D_WIDTH_DFLT
) (
  input  logic                     clk,
  input  logic                     rstn,
  die2die_link_rx_if.slave         bus,
  output logic                     credit_ret,
  output logic [$clog2(CREDITS):0] occupancy,
  output logic                     ovf_err,
  output logic                     par_err
);
  localparam int unsigned CntW = $clog2(CREDITS) + 1;
  localparam int unsigned SumW = CntW + 1;

  logic             par_bad, push_ok, pop, full, drop_ovf, fifo_push;
  logic [WIDTH-1:0] head;
  logic [CntW-1:0]  count;
  logic [CntW-1:0]  pend_q, pend_d;
  logic [SumW-1:0]  pend_sum;
  logic             ovf_q;

`ifdef D2D_RX_PARITY_EN
  logic par_q;
  assign par_bad = bus.link_valid & (^{bus.link_data, bus.link_par});
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) par_q <= 1'b0;
    else       par_q <= par_q | par_bad;
  end
  assign par_err = par_q;
`else
  assign par_bad = 1'b0;
  assign par_err = 1'b0;
`endif

  assign push_ok       = bus.link_valid & ~par_bad;
  assign bus.out_valid = (count != '0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign full          = (count == CntW'(CREDITS));
  // A pop in the same cycle frees the slot, so a push at full is still legal then.
  assign drop_ovf      = push_ok & full & ~pop;
  assign fifo_push     = push_ok & ~drop_ovf;

  die2die_rx_fifo #(
    .CREDITS (CREDITS),
    .WIDTH   (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (bus.link_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign bus.out_data = bus.out_valid ? head : '0;
  assign occupancy    = count;

  // Parity-dropped flits still owe the transmitter a credit; overflow drops do not.
  always_comb begin
    pend_sum = {1'b0, pend_q} + SumW'(pop) + SumW'(par_bad) - SumW'(credit_ret);
    if (pend_sum > SumW'(CREDITS)) pend_d = CntW'(CREDITS);
    else                           pend_d = pend_sum[CntW-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_q | drop_ovf;
    end
  end

  assign credit_ret = (pend_q != '0);
  assign ovf_err    = ovf_q;

endmodule

// File: tb/tb_die2die_link_rx.sv
// Randomised and directed bench for die2die_link_rx (CREDITS=8 and CREDITS=5 instances)
// against a queue-based reference model.
module tb_die2die_link_rx;
  import d2d_pkg::*;

  localparam int unsigned W = 64;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  die2die_link_rx_if #(.WIDTH(W)) if8 ();
  die2die_link_rx_if #(.WIDTH(W)) if5 ();

  logic         lv [2];
  logic [W-1:0] ld [2];
  logic         lp [2];
  logic         rdy [2];
  logic         c_ret [2];
  logic [3:0]   occ [2];
  logic         ovf [2];
  logic         perr [2];
  logic         o_v [2];
  logic [W-1:0] o_d [2];

  assign if8.link_valid = lv[0];
  assign if8.link_data  = ld[0];
  assign if8.out_ready  = rdy[0];
  assign if5.link_valid = lv[1];
  assign if5.link_data  = ld[1];
  assign if5.out_ready  = rdy[1];
`ifdef D2D_RX_PARITY_EN
  assign if8.link_par   = lp[0];
  assign if5.link_par   = lp[1];
`endif
  assign o_v[0] = if8.out_valid;
  assign o_d[0] = if8.out_data;
  assign o_v[1] = if5.out_valid;
  assign o_d[1] = if5.out_data;

  die2die_link_rx #(.CREDITS(8), .WIDTH(W)) u_dut8 (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (if8),
    .credit_ret (c_ret[0]),
    .occupancy  (occ[0]),
    .ovf_err    (ovf[0]),
    .par_err    (perr[0])
  );

  die2die_link_rx #(.CREDITS(5), .WIDTH(W)) u_dut5 (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (if5),
    .credit_ret (c_ret[1]),
    .occupancy  (occ[1]),
    .ovf_err    (ovf[1]),
    .par_err    (perr[1])
  );

  // Reference model state
  logic [W-1:0] mq [2][$];
  int unsigned  pend [2];
  bit           m_ovf [2];
  bit           m_par [2];
  int unsigned  cred_seen [2];
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check_eq(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned depth(int d);
    return (d == 0) ? 8 : 5;
  endfunction

  // Applies one clock edge worth of the behavioural rules to the model.
  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      bit pop, bad, full, dec;
      pop  = (mq[d].size() != 0) && rdy[d];
      bad  = 1'b0;
`ifdef D2D_RX_PARITY_EN
      bad  = lv[d] && (^{ld[d], lp[d]});
`endif
      full = (mq[d].size() == depth(d));
      dec  = (pend[d] > 0);
      if (pop) void'(mq[d].pop_front());
      if (lv[d] && !bad) begin
        if (full && !pop) m_ovf[d] = 1'b1;
        else              mq[d].push_back(ld[d]);
      end
      if (bad) m_par[d] = 1'b1;
      pend[d] = pend[d] + int'(pop) + int'(bad) - int'(dec);
      if (pend[d] > depth(d)) pend[d] = depth(d);
    end
  endtask

  task automatic check_all(string ph);
    for (int d = 0; d < 2; d++) begin
      logic [W-1:0] exp_d;
      exp_d = (mq[d].size() != 0) ? mq[d][0] : '0;
      check_eq($sformatf("%s/d%0d/occ", ph, d), W'(occ[d]), W'(mq[d].size()));
      check_eq($sformatf("%s/d%0d/valid", ph, d), W'(o_v[d]), W'(mq[d].size() != 0));
      check_eq($sformatf("%s/d%0d/data", ph, d), o_d[d], exp_d);
      check_eq($sformatf("%s/d%0d/credit", ph, d), W'(c_ret[d]), W'(pend[d] != 0));
      check_eq($sformatf("%s/d%0d/ovf", ph, d), W'(ovf[d]), W'(m_ovf[d]));
      check_eq($sformatf("%s/d%0d/par", ph, d), W'(perr[d]), W'(m_par[d]));
      if (c_ret[d]) cred_seen[d]++;
    end
  endtask

  task automatic tick(string ph);
    model_step();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      lv[d]  = 1'b0;
      rdy[d] = 1'b0;
      ld[d]  = '0;
      lp[d]  = 1'b0;
    end
  endtask

  task automatic drive(int d, logic v, logic [W-1:0] data, logic r);
    lv[d]  = v;
    ld[d]  = data;
    lp[d]  = ^data;
    rdy[d] = r;
  endtask

  task automatic do_reset();
    idle();
    rstn = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("rst/d%0d/occ", d), W'(occ[d]), '0);
      check_eq($sformatf("rst/d%0d/valid", d), W'(o_v[d]), '0);
      check_eq($sformatf("rst/d%0d/credit", d), W'(c_ret[d]), '0);
      check_eq($sformatf("rst/d%0d/ovf", d), W'(ovf[d]), '0);
      mq[d].delete();
      pend[d]      = 0;
      m_ovf[d]     = 1'b0;
      m_par[d]     = 1'b0;
      cred_seen[d] = 0;
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned tx_cred, sent, cyc;

    // 1: idle after reset release
    do_reset();
    repeat (20) tick("t1");
    check_eq("t1/credits", W'(cred_seen[0] + cred_seen[1]), '0);

    // 2: fill with out_ready low, then drain in order
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1'b1, W'(i), 1'b0);
      tick("t2fill");
    end
    idle();
    check_eq("t2/occ_full", W'(occ[0]), W'(8));
    check_eq("t2/head", o_d[0], W'(1));
    cred_seen[0] = 0;
    for (int i = 1; i <= 8; i++) begin
      check_eq("t2/order", o_d[0], W'(i));
      drive(0, 1'b0, '0, 1'b1);
      tick("t2drain");
      if (i == 1) check_eq("t2/first_credit", W'(c_ret[0]), W'(1));
    end
    idle();
    repeat (4) tick("t2tail");
    check_eq("t2/credits", W'(cred_seen[0]), W'(8));

    // 3: push+pop at full is accepted; push at full without pop overflows
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, W'(32'h10 + i), 1'b0);
      tick("t3fill");
    end
    cred_seen[0] = 0;
    drive(0, 1'b1, W'(32'haa), 1'b1);
    tick("t3pp");
    check_eq("t3/ovf_after_pp", W'(ovf[0]), '0);
    check_eq("t3/occ_after_pp", W'(occ[0]), W'(8));
    drive(0, 1'b1, W'(32'hbb), 1'b0);
    tick("t3ovf");
    check_eq("t3/ovf_set", W'(ovf[0]), W'(1));
    check_eq("t3/occ_after_ovf", W'(occ[0]), W'(8));
    idle();
    repeat (5) tick("t3tail");
    check_eq("t3/credits", W'(cred_seen[0]), W'(1));

    // 4: streaming push+pop, pointers wrap many times
    do_reset();
    drive(0, 1'b1, W'(32'h100), 1'b0);
    tick("t4prime");
    for (int i = 1; i <= 100; i++) begin
      drive(0, 1'b1, W'(32'h100 + i), 1'b1);
      tick("t4");
      check_eq("t4/occ_one", W'(occ[0]), W'(1));
      check_eq("t4/credit_hi", W'(c_ret[0]), W'(1));
    end
    idle();
    repeat (3) tick("t4tail");

    // 5: CREDITS=5 with a credit-honouring sender and random consumer
    do_reset();
    tx_cred = 5;
    sent = 0;
    cyc = 0;
    while (!(sent == 23 && mq[1].size() == 0 && pend[1] == 0) && cyc < 1000) begin
      if (sent < 23 && tx_cred > 0 && ($urandom % 2 == 1)) begin
        drive(1, 1'b1, W'(32'h500 + sent), ($urandom % 2 == 1));
        sent++;
        tx_cred--;
      end else begin
        drive(1, 1'b0, '0, ($urandom % 2 == 1));
      end
      tick("t5");
      if (c_ret[1]) tx_cred++;
      cyc++;
    end
    idle();
    check_eq("t5/timeout", W'(cyc < 1000), W'(1));
    check_eq("t5/credits", W'(cred_seen[1]), W'(23));
    check_eq("t5/ovf", W'(ovf[1]), '0);

    // Random traffic on the 8-deep instance, including overflow and bad parity
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] data;
      data = {$urandom, $urandom};
      drive(0, ($urandom % 4 != 0), data, ($urandom % 3 != 0));
      if ($urandom % 8 == 0) lp[0] = ~lp[0];
      tick("rnd");
    end
    idle();
    repeat (10) tick("rndtail");

`ifdef D2D_RX_PARITY_EN
    // 6: bad parity flit is dropped but its credit is returned
    do_reset();
    lv[0] = 1'b1;
    ld[0] = W'(3);
    lp[0] = 1'b1;
    tick("t6bad");
    check_eq("t6/par_err", W'(perr[0]), W'(1));
    check_eq("t6/occ", W'(occ[0]), '0);
    check_eq("t6/credit", W'(c_ret[0]), W'(1));
    idle();
    tick("t6idle");
    check_eq("t6/credit_lo", W'(c_ret[0]), '0);
    drive(0, 1'b1, W'(7), 1'b0);
    tick("t6good");
    lv[0]  = 1'b1;
    ld[0]  = W'(3);
    lp[0]  = 1'b1;
    rdy[0] = 1'b1;
    tick("t6both");
    check_eq("t6/pulse1", W'(c_ret[0]), W'(1));
    idle();
    tick("t6p2");
    check_eq("t6/pulse2", W'(c_ret[0]), W'(1));
    tick("t6p3");
    check_eq("t6/pulse_end", W'(c_ret[0]), '0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
